// File: rtl/tdu_pkg.sv
// Shared types for the trade decision unit: position encoding and its width.
package tdu_pkg;

  localparam int POS_W = 2;

  typedef enum logic [POS_W-1:0] {
    FLAT  = 2'b00,
    LONG  = 2'b01,
    SHORT = 2'b10,
    COOL  = 2'b11
  } position_t;

endpackage

// File: rtl/tdu_weighted_score.sv
// Combinational weighted-vote adder: sums the weight of every channel whose vote is set.
module tdu_weighted_score #(
  parameter int N_STRAT  = 3,
  parameter int WEIGHT_W = 3,
  parameter int SCORE_W  = 5
) (
  input  logic [N_STRAT-1:0]          i_votes,
  input  logic [N_STRAT*WEIGHT_W-1:0] i_weights,
  output logic [SCORE_W-1:0]          o_score
);

  always_comb begin
    // NOTE: assigning a default before the loop keeps this purely combinational (no latch).
    o_score = '0;
    for (int i = 0; i < N_STRAT; i++) begin
      if (i_votes[i]) o_score = o_score + SCORE_W'(i_weights[i*WEIGHT_W +: WEIGHT_W]);
    end
  end

endmodule

// File: rtl/trade_decision_unit.sv
// Weighted vote scoring, persistence confirmation and FLAT/LONG/SHORT/COOL position FSM.
// Define TDU_SHORT_EN to allow FLAT -> SHORT entries; otherwise SHORT is unreachable.
module trade_decision_unit
  import tdu_pkg::*;
#(
  parameter int N_STRAT        = 3,
  parameter int WEIGHT_W       = 3,
  parameter int SCORE_W        = 5,
  parameter int CONFIRM_CYCLES = 2,
  parameter int COOLDOWN       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [N_STRAT-1:0]          buy_vec,
  input  logic [N_STRAT-1:0]          sell_vec,
  input  logic [N_STRAT*WEIGHT_W-1:0] buy_weights,
  input  logic [N_STRAT*WEIGHT_W-1:0] sell_weights,
  input  logic [SCORE_W-1:0]          buy_threshold,
  input  logic [SCORE_W-1:0]          sell_threshold,
  input  logic                        force_flat,
  output logic                        buy_signal,
  output logic                        sell_signal,
  output logic [POS_W-1:0]            position,
  output logic [SCORE_W-1:0]          buy_score,
  output logic [SCORE_W-1:0]          sell_score
);

  localparam int CNT_W = $clog2(CONFIRM_CYCLES + 1);
  localparam int CCW   = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CONFIRM_CYCLES);
  localparam logic [CCW-1:0]   COOL_LOAD = (COOLDOWN > 0) ? CCW'(COOLDOWN - 1) : '0;
  localparam position_t        EXIT_POS  = (COOLDOWN > 0) ? COOL : FLAT;

  if (SCORE_W < WEIGHT_W + $clog2(N_STRAT + 1)) begin : g_bad_score_w
    $error("SCORE_W too narrow for N_STRAT weighted votes");
  end

  logic [SCORE_W-1:0] w_buy_sum, w_sell_sum;
  logic [SCORE_W-1:0] r_buy_score, r_sell_score;
  logic               r_score_valid;
  logic [CNT_W-1:0]   r_buy_cnt, r_sell_cnt, w_buy_cnt_nxt, w_sell_cnt_nxt;
  logic               w_buy_ok, w_sell_ok;
  logic [CCW-1:0]     r_cool_cnt;
  position_t          r_pos;
  logic               r_buy_signal, r_sell_signal;

  tdu_weighted_score #(.N_STRAT(N_STRAT), .WEIGHT_W(WEIGHT_W), .SCORE_W(SCORE_W)) u_buy_sum (
    .i_votes(buy_vec), .i_weights(buy_weights), .o_score(w_buy_sum)
  );

  tdu_weighted_score #(.N_STRAT(N_STRAT), .WEIGHT_W(WEIGHT_W), .SCORE_W(SCORE_W)) u_sell_sum (
    .i_votes(sell_vec), .i_weights(sell_weights), .o_score(w_sell_sum)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buy_score   <= '0;
      r_sell_score  <= '0;
      r_score_valid <= 1'b0;
    end else begin
      r_score_valid <= in_valid;
      if (in_valid) begin
        r_buy_score  <= w_buy_sum;
        r_sell_score <= w_sell_sum;
      end
    end
  end

  assign w_buy_ok  = (r_buy_cnt == CNT_MAX);
  assign w_sell_ok = (r_sell_cnt == CNT_MAX);
  assign w_buy_cnt_nxt  = (r_buy_score >= buy_threshold)
                        ? (w_buy_ok ? r_buy_cnt : r_buy_cnt + CNT_W'(1)) : '0;
  assign w_sell_cnt_nxt = (r_sell_score >= sell_threshold)
                        ? (w_sell_ok ? r_sell_cnt : r_sell_cnt + CNT_W'(1)) : '0;

  // Counter updates sit before the case so any state action below overrides them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos         <= FLAT;
      r_buy_cnt     <= '0;
      r_sell_cnt    <= '0;
      r_cool_cnt    <= '0;
      r_buy_signal  <= 1'b0;
      r_sell_signal <= 1'b0;
    end else begin
      r_buy_signal  <= 1'b0;
      r_sell_signal <= 1'b0;
      if (r_score_valid) begin
        r_buy_cnt  <= w_buy_cnt_nxt;
        r_sell_cnt <= w_sell_cnt_nxt;
      end
      case (r_pos)
        FLAT: begin
          if (w_buy_ok && w_sell_ok) begin
            r_buy_cnt  <= '0;
            r_sell_cnt <= '0;
          end else if (w_buy_ok) begin
            r_pos        <= LONG;
            r_buy_signal <= 1'b1;
            r_buy_cnt    <= '0;
            r_sell_cnt   <= '0;
          end else if (w_sell_ok) begin
`ifdef TDU_SHORT_EN
            r_pos         <= SHORT;
            r_sell_signal <= 1'b1;
`endif
            r_buy_cnt  <= '0;
            r_sell_cnt <= '0;
          end
        end
        LONG: begin
          if (force_flat || w_sell_ok) begin
            r_pos         <= EXIT_POS;
            r_cool_cnt    <= COOL_LOAD;
            r_sell_signal <= 1'b1;
            r_buy_cnt     <= '0;
            r_sell_cnt    <= '0;
          end
        end
        SHORT: begin
          if (force_flat || w_buy_ok) begin
            r_pos        <= EXIT_POS;
            r_cool_cnt   <= COOL_LOAD;
            r_buy_signal <= 1'b1;
            r_buy_cnt    <= '0;
            r_sell_cnt   <= '0;
          end
        end
        COOL: begin
          r_buy_cnt  <= '0;
          r_sell_cnt <= '0;
          if (r_cool_cnt == '0) r_pos <= FLAT;
          else                  r_cool_cnt <= r_cool_cnt - CCW'(1);
        end
        default: r_pos <= FLAT;
      endcase
    end
  end

  assign buy_signal  = r_buy_signal;
  assign sell_signal = r_sell_signal;
  assign position    = r_pos;
  assign buy_score   = r_buy_score;
  assign sell_score  = r_sell_score;

endmodule
